// File: rtl/sci2_rx.sv
// SCI2 serial receiver: synchronises the serial clock/data, deframes 13-bit
// words, checks parity/stop/sequence and groups words into command frames.
module sci2_rx #(
    parameter int unsigned W_DATA    = 9,
    parameter int unsigned W_ADDR    = 5,
    parameter int unsigned MAX_WORDS = 5,
    parameter int unsigned IDLE_BITS = 2,
    parameter int unsigned TIMEOUT   = 256,
    parameter logic        MARK_CMD  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_ADDR-1:0] chip_addr,
    input  logic              sci_clk,
    input  logic              sci_data,
    output logic              word_valid,
    output logic [W_DATA-1:0] word_data,
    output logic              word_mark,
    output logic [2:0]        word_index,
    output logic [2:0]        word_err,
    output logic              frame_done,
    output logic [2:0]        frame_words,
    output logic              frame_err,
    output logic              frame_hit,
    output logic              rx_busy
);

    localparam int unsigned W_BIT  = $clog2(W_DATA);
    localparam int unsigned W_IDLE = $clog2(IDLE_BITS + 1);
    localparam int unsigned W_TMO  = $clog2(TIMEOUT + 1);
    localparam int unsigned W_CNT  = 3;
    localparam logic [2:0]  IDX_NONE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_MARK,
        S_PAR,
        S_STOP
    } state_e;

    // Two-flop synchronisers plus an extra clock stage for rising-edge detect
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic dat_s1_q, dat_s2_q;

    // Synchroniser chain; idles high out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= sci_clk;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= sci_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    logic sample_c;
    logic bit_c;
    assign sample_c = clk_s2_q & ~clk_s3_q;
    assign bit_c    = dat_s2_q;

    state_e              state_q, state_d;
    logic [W_BIT-1:0]    bit_cnt_q, bit_cnt_d;
    logic [W_IDLE-1:0]   idle_cnt_q, idle_cnt_d;
    logic [W_TMO-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [W_DATA-1:0]   shift_q, shift_d;
    logic                mark_bit_q, mark_bit_d;
    logic                par_bit_q, par_bit_d;
    logic                frame_open_q, frame_open_d;
    logic [W_CNT-1:0]    frame_cnt_q, frame_cnt_d;
    logic                frame_acc_q, frame_acc_d;
    logic                hit_q, hit_d;

    logic                word_valid_q, word_valid_d;
    logic [W_DATA-1:0]   word_data_q, word_data_d;
    logic                word_mark_q, word_mark_d;
    logic [2:0]          word_index_q, word_index_d;
    logic [2:0]          word_err_q, word_err_d;
    logic                frame_done_q, frame_done_d;
    logic [2:0]          frame_words_q, frame_words_d;
    logic                frame_err_q, frame_err_d;
    logic                frame_hit_q, frame_hit_d;
    logic                rx_busy_q, rx_busy_d;

    logic                timeout_c;
    logic                is_cmd_c;
    logic                seq_c;
    logic                par_err_c;
    logic                stop_err_c;
    logic [2:0]          idx_c;
    logic [2:0]          err_c;

    // Next-state, deframing, word checks and frame bookkeeping
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        shift_d       = shift_q;
        mark_bit_d    = mark_bit_q;
        par_bit_d     = par_bit_q;
        frame_open_d  = frame_open_q;
        frame_cnt_d   = frame_cnt_q;
        frame_acc_d   = frame_acc_q;
        hit_d         = hit_q;
        word_valid_d  = 1'b0;
        word_data_d   = word_data_q;
        word_mark_d   = word_mark_q;
        word_index_d  = word_index_q;
        word_err_d    = word_err_q;
        frame_done_d  = 1'b0;
        frame_words_d = frame_words_q;
        frame_err_d   = frame_err_q;
        frame_hit_d   = frame_hit_q;
        is_cmd_c      = (mark_bit_q == MARK_CMD);
        seq_c         = 1'b0;
        par_err_c     = ~(^{shift_q, mark_bit_q, par_bit_q});
        stop_err_c    = ~bit_c;
        idx_c         = IDX_NONE;
        err_c         = 3'b000;

        // Watchdog only runs inside a word; any sample restarts it
        if (state_q == S_IDLE || sample_c) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + W_TMO'(1);
        end
        timeout_c = (state_q != S_IDLE) && !sample_c &&
                    (tmo_cnt_q == W_TMO'(TIMEOUT - 1));

        case (state_q)
            S_IDLE: begin
                if (sample_c) begin
                    if (!bit_c) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else if (idle_cnt_q < W_IDLE'(IDLE_BITS)) begin
                        idle_cnt_d = idle_cnt_q + W_IDLE'(1);
                        if (idle_cnt_d == W_IDLE'(IDLE_BITS) && frame_open_q) begin
                            frame_done_d  = 1'b1;
                            frame_words_d = frame_cnt_q;
                            frame_err_d   = frame_acc_q;
                            frame_hit_d   = hit_q;
                            frame_open_d  = 1'b0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (sample_c) begin
                    shift_d   = {bit_c, shift_q[W_DATA-1:1]};
                    bit_cnt_d = bit_cnt_q + W_BIT'(1);
                    if (bit_cnt_q == W_BIT'(W_DATA - 1)) begin
                        state_d = S_MARK;
                    end
                end
            end
            S_MARK: begin
                if (sample_c) begin
                    mark_bit_d = bit_c;
                    state_d    = S_PAR;
                end
            end
            S_PAR: begin
                if (sample_c) begin
                    par_bit_d = bit_c;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (sample_c) begin
                    state_d    = S_IDLE;
                    idle_cnt_d = '0;
                    // Classify the word against the current frame state
                    if (is_cmd_c) begin
                        if (frame_open_q) begin
                            frame_done_d  = 1'b1;
                            frame_words_d = frame_cnt_q;
                            frame_err_d   = 1'b1;
                            frame_hit_d   = hit_q;
                            seq_c         = 1'b1;
                        end
                        frame_open_d = 1'b1;
                        frame_cnt_d  = W_CNT'(1);
                        hit_d        = (shift_q[W_ADDR-1:0] == chip_addr) | shift_q[W_ADDR];
                        idx_c        = 3'd0;
                    end else if (!frame_open_q) begin
                        seq_c = 1'b1;
                    end else if (frame_cnt_q < W_CNT'(MAX_WORDS)) begin
                        idx_c       = frame_cnt_q;
                        frame_cnt_d = frame_cnt_q + W_CNT'(1);
                    end else begin
                        seq_c = 1'b1;
                    end
                    err_c = {seq_c, stop_err_c, par_err_c};
                    if (is_cmd_c) begin
                        frame_acc_d = |err_c;
                    end else if (frame_open_q) begin
                        frame_acc_d = frame_acc_q | (|err_c);
                    end
                    word_valid_d = 1'b1;
                    word_data_d  = shift_q;
                    word_mark_d  = mark_bit_q;
                    word_index_d = idx_c;
                    word_err_d   = err_c;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Lost serial clock mid-word: drop the word and any open frame
        if (timeout_c) begin
            state_d = S_IDLE;
            if (frame_open_q) begin
                frame_done_d  = 1'b1;
                frame_words_d = frame_cnt_q;
                frame_err_d   = 1'b1;
                frame_hit_d   = hit_q;
                frame_open_d  = 1'b0;
            end
        end

        rx_busy_d = (state_d != S_IDLE) || frame_open_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            shift_q       <= '0;
            mark_bit_q    <= 1'b0;
            par_bit_q     <= 1'b0;
            frame_open_q  <= 1'b0;
            frame_cnt_q   <= '0;
            frame_acc_q   <= 1'b0;
            hit_q         <= 1'b0;
            word_valid_q  <= 1'b0;
            word_data_q   <= '0;
            word_mark_q   <= 1'b0;
            word_index_q  <= IDX_NONE;
            word_err_q    <= 3'b000;
            frame_done_q  <= 1'b0;
            frame_words_q <= 3'd0;
            frame_err_q   <= 1'b0;
            frame_hit_q   <= 1'b0;
            rx_busy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            shift_q       <= shift_d;
            mark_bit_q    <= mark_bit_d;
            par_bit_q     <= par_bit_d;
            frame_open_q  <= frame_open_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_acc_q   <= frame_acc_d;
            hit_q         <= hit_d;
            word_valid_q  <= word_valid_d;
            word_data_q   <= word_data_d;
            word_mark_q   <= word_mark_d;
            word_index_q  <= word_index_d;
            word_err_q    <= word_err_d;
            frame_done_q  <= frame_done_d;
            frame_words_q <= frame_words_d;
            frame_err_q   <= frame_err_d;
            frame_hit_q   <= frame_hit_d;
            rx_busy_q     <= rx_busy_d;
        end
    end

    assign word_valid  = word_valid_q;
    assign word_data   = word_data_q;
    assign word_mark   = word_mark_q;
    assign word_index  = word_index_q;
    assign word_err    = word_err_q;
    assign frame_done  = frame_done_q;
    assign frame_words = frame_words_q;
    assign frame_err   = frame_err_q;
    assign frame_hit   = frame_hit_q;
    assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_sci2_rx.sv
// Self-checking bench for sci2_rx: word-level reference model, randomized frames.
module tb_sci2_rx;

    localparam int unsigned TIMEOUT = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] chip_addr;
    logic       sci_clk;
    logic       sci_data;
    logic       word_valid;
    logic [8:0] word_data;
    logic       word_mark;
    logic [2:0] word_index;
    logic [2:0] word_err;
    logic       frame_done;
    logic [2:0] frame_words;
    logic       frame_err;
    logic       frame_hit;
    logic       rx_busy;

    always #5 clk = ~clk;

    sci2_rx dut (
        .clk         (clk),
        .rst         (rst),
        .chip_addr   (chip_addr),
        .sci_clk     (sci_clk),
        .sci_data    (sci_data),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_mark   (word_mark),
        .word_index  (word_index),
        .word_err    (word_err),
        .frame_done  (frame_done),
        .frame_words (frame_words),
        .frame_err   (frame_err),
        .frame_hit   (frame_hit),
        .rx_busy     (rx_busy)
    );

    // Events: word = {01, data, mark, index, err}; frame = {10, 0.., words, err, hit}
    typedef logic [17:0] ev_t;
    ev_t obs_q[$];
    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference-model frame state
    bit  m_open;
    int  m_cnt;
    bit  m_hit;
    bit  m_acc;

    // Collect every reported event in arrival order
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) obs_q.push_back({2'b10, 11'b0, frame_words, frame_err, frame_hit});
            if (word_valid) obs_q.push_back({2'b01, word_data, word_mark, word_index, word_err});
        end
    end

    function automatic ev_t frame_ev(input int words, input bit err, input bit hit);
        return {2'b10, 11'b0, 3'(words), err, hit};
    endfunction

    // Word-level framing rules
    function automatic void model_word(input logic [8:0] d, input logic mk,
                                       input bit bad_par, input bit bad_stop);
        logic       seq;
        logic [2:0] idx;
        logic [2:0] err;
        seq = 1'b0;
        idx = 3'd7;
        if (mk) begin
            if (m_open) begin
                exp_q.push_back(frame_ev(m_cnt, 1'b1, m_hit));
                seq = 1'b1;
            end
            m_open = 1'b1;
            m_cnt  = 1;
            m_hit  = (d[4:0] == chip_addr) || d[5];
            idx    = 3'd0;
        end else if (!m_open) begin
            seq = 1'b1;
        end else if (m_cnt < 5) begin
            idx   = 3'(m_cnt);
            m_cnt = m_cnt + 1;
        end else begin
            seq = 1'b1;
        end
        err = {seq, bad_stop, bad_par};
        if (mk) m_acc = |err;
        else if (m_open) m_acc = m_acc | (|err);
        exp_q.push_back({2'b01, d, mk, idx, err});
    endfunction

    function automatic void model_close(input bit forced_err);
        if (m_open) exp_q.push_back(frame_ev(m_cnt, m_acc | forced_err, m_hit));
        m_open = 1'b0;
    endfunction

    // One serial bit: data changes with the falling edge, sampled on the rising edge
    task automatic send_bit(input logic b);
        sci_clk  = 1'b0;
        sci_data = b;
        repeat (4) @(negedge clk);
        sci_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic tx_word(input logic [8:0] d, input logic mk,
                           input bit bad_par, input bit bad_stop);
        logic p;
        model_word(d, mk, bad_par, bad_stop);
        p = ~(^d ^ mk) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 9; i++) send_bit(d[i]);
        send_bit(mk);
        send_bit(p);
        send_bit(~bad_stop);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({word_valid, frame_done, rx_busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b required 000", {word_valid, frame_done, rx_busy});
        end
        n_tests++;
        if (word_index !== 3'd7) begin
            n_fail++; $display("FAIL reset_index: got %0d required 7", word_index);
        end
        n_tests++;
        if ({word_data, word_mark, word_err, frame_words, frame_err, frame_hit} !== 18'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0",
                               {word_data, word_mark, word_err, frame_words, frame_err, frame_hit});
        end
        rst = 1'b0;
        m_open = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_two_word;
        ev_t e, o;
        chip_addr = 5'd1;
        tx_word(9'h081, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (rx_busy !== 1'b1) begin
            n_fail++; $display("FAIL two_word_busy: got %b required 1", rx_busy);
        end
        tx_word(9'h084, 1'b0, 1'b0, 1'b0);
        send_idle(2);
        model_close(1'b0);
        repeat (10) @(negedge clk);
        n_tests++;
        if (rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL two_word_idle_busy: got %b required 0", rx_busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL two_word: got none required %h", e); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL two_word: got %h required %h", o, e); end end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL two_word_extra: got %0d events required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_hit;
        ev_t e, o;
        chip_addr = 5'd2;
        tx_word(9'h081, 1'b1, 1'b0, 1'b0);
        tx_word(9'h084, 1'b0, 1'b0, 1'b0);
        send_idle(2);
        model_close(1'b0);
        tx_word(9'h0A1, 1'b1, 1'b0, 1'b0);
        tx_word(9'h084, 1'b0, 1'b0, 1'b0);
        send_idle(2);
        model_close(1'b0);
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL hit: got none required %h", e); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL hit: got %h required %h", o, e); end end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL hit_extra: got %0d events required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_max_words;
        ev_t e, o;
        chip_addr = 5'd1;
        tx_word(9'h081, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tx_word(9'(9'h100 + i), 1'b0, 1'b0, 1'b0);
        send_idle(2);
        model_close(1'b0);
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL max_words: got none required %h", e); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL max_words: got %h required %h", o, e); end end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL max_words_extra: got %0d events required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_word_errors;
        ev_t e, o;
        chip_addr = 5'd3;
        tx_word(9'h043, 1'b1, 1'b1, 1'b0);
        send_idle(2);
        model_close(1'b0);
        tx_word(9'h0C3, 1'b1, 1'b0, 1'b1);
        send_idle(2);
        model_close(1'b0);
        tx_word(9'h1E3, 1'b1, 1'b0, 1'b0);
        tx_word(9'h155, 1'b0, 1'b0, 1'b0);
        send_idle(2);
        model_close(1'b0);
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL word_errors: got none required %h", e); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL word_errors: got %h required %h", o, e); end end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL word_errors_extra: got %0d events required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_orphan_info;
        ev_t e, o;
        tx_word(9'h000, 1'b0, 1'b0, 1'b0);
        send_idle(2);
        model_close(1'b0);
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL orphan: got none required %h", e); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL orphan: got %h required %h", o, e); end end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL orphan_extra: got %0d events required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_timeout;
        ev_t e, o;
        logic [8:0] d;
        chip_addr = 5'd1;
        d = 9'h0F5;
        tx_word(9'h081, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        model_close(1'b1);
        repeat (TIMEOUT + 20) @(negedge clk);
        n_tests++;
        if (rx_busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_busy: got %b required 0", rx_busy);
        end
        send_idle(2);
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL timeout: got none required %h", e); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL timeout: got %h required %h", o, e); end end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL timeout_extra: got %0d events required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_reset_recovery;
        ev_t e, o;
        chip_addr = 5'd1;
        tx_word(9'h081, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Everything the model expected before reset was discarded with the frame
        m_open = 1'b0;
        exp_q.delete();
        exp_q.push_back({2'b01, 9'h081, 1'b1, 3'd0, 3'b000});
        obs_q.delete();
        n_tests++;
        if (word_index !== 3'd7) begin
            n_fail++; $display("FAIL reset_mid_index: got %0d required 7", word_index);
        end
        exp_q.delete();
        send_idle(2);
        tx_word(9'h081, 1'b1, 1'b0, 1'b0);
        send_idle(2);
        model_close(1'b0);
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL reset_recovery: got none required %h", e); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL reset_recovery: got %h required %h", o, e); end end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL reset_recovery_extra: got %0d events required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_random;
        ev_t e, o;
        int  n_info;
        for (int f = 0; f < 15; f++) begin
            chip_addr = 5'($urandom);
            tx_word(9'($urandom), 1'b1, ($urandom_range(0, 7) == 0), 1'b0);
            n_info = $urandom_range(0, 5);
            for (int w = 0; w < n_info; w++) begin
                if ($urandom_range(0, 1) == 1) send_idle(1);
                tx_word(9'($urandom), 1'b0, ($urandom_range(0, 7) == 0), 1'b0);
            end
            if ($urandom_range(0, 3) != 0) begin
                send_idle(2);
                model_close(1'b0);
            end
        end
        send_idle(2);
        model_close(1'b0);
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL random: got none required %h", e); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL random: got %h required %h", o, e); end end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL random_extra: got %0d events required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    initial begin
        rst       = 1'b1;
        chip_addr = 5'd0;
        sci_clk   = 1'b1;
        sci_data  = 1'b1;
        m_open    = 1'b0;
        m_cnt     = 0;
        m_hit     = 1'b0;
        m_acc     = 1'b0;
        test_reset();
        test_two_word();
        test_hit();
        test_max_words();
        test_word_errors();
        test_orphan_info();
        test_timeout();
        test_reset_recovery();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
